// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream blocks.
package fifo_rd_pkg;

  // Depth of the prefetch/skid buffer; two entries cover the one-cycle read latency.
  localparam int SKID_DEPTH = 2;

  // Occupancy has to represent 0..SKID_DEPTH inclusive.
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  typedef logic [OCC_W-1:0] occ_t;

  // Valid/ready handshake pair, shared with future stream blocks.
  typedef struct packed {
    logic valid;
    logic ready;
  } stream_hs_t;

  // A word moves across the interface when both sides agree.
  function automatic logic hs_fire(input stream_hs_t hs);
    return hs.valid & hs.ready;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry ordered buffer. The head is always slot0, so the head value only
// changes when a pop happens or when a word is pushed into an empty buffer.
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output occ_t              occ_o
);

  logic [DATA_W-1:0] slot0_q;
  logic [DATA_W-1:0] slot1_q;
  occ_t              occ_q;
  logic              pop_ok;
  logic              push_ok;

  // Qualify requests so a stray pop on empty or push on full cannot corrupt order.
  always_comb begin
    pop_ok  = pop_i & (occ_q != '0);
    push_ok = push_i & ((occ_q != occ_t'(SKID_DEPTH)) | pop_ok);
  end

  // Slot and occupancy update; a simultaneous push and pop keeps occupancy
  // unchanged while the second slot slides forward and the new word lands behind it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= '0;
    end else if (clear_i) begin
      occ_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (occ_q == '0) slot0_q <= push_data_i;
          else             slot1_q <= push_data_i;
          occ_q <= occ_q + occ_t'(1);
        end
        2'b01: begin
          slot0_q <= slot1_q;
          occ_q   <= occ_q - occ_t'(1);
        end
        2'b11: begin
          if (occ_q == occ_t'(1)) begin
            slot0_q <= push_data_i;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o = slot0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port with one-cycle registered latency and presents the
// words as a valid/ready stream, sustaining one word per clock.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic              fifo_re_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              fifo_avail_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              busy_o
);

  logic              run_q;
  logic              inflt_q;
  logic              drop_q;
  logic [CNT_W-1:0]  cnt_q;
  occ_t              occ;
  logic [DATA_W-1:0] head;
  stream_hs_t        hs;
  logic              pop;
  logic [OCC_W:0]    level;
  logic              issue;
  logic              capture;

  // Handshake, projected occupancy after this cycle, and the read-issue decision.
  // run_q keeps reads off while reset is asserted and for the first cycle after
  // release, so the FIFO is never drained into a buffer that is being cleared.
  always_comb begin
    hs.valid = (occ != '0);
    hs.ready = ready_i;
    pop      = hs_fire(hs);
    level    = {1'b0, occ} + {{OCC_W{1'b0}}, inflt_q} - {{OCC_W{1'b0}}, pop};
    issue    = run_q & fifo_avail_i & ~flush_i & (level < (OCC_W+1)'(SKID_DEPTH));
    capture  = inflt_q & ~drop_q & ~flush_i;
  end

  skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clear_i     (flush_i),
    .push_i      (capture),
    .push_data_i (fifo_data_i),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (occ)
  );

  // In-flight tracking; drop_q marks a word that was already requested when a
  // flush hit, so it is thrown away rather than captured.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q   <= 1'b0;
      inflt_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      inflt_q <= issue;
      drop_q  <= flush_i & inflt_q;
    end
  end

  // Delivered-word counter; flush clears it and a pop in the flush cycle is not counted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fifo_re_o = issue;
  assign data_o    = head;
  assign valid_o   = hs.valid;
  assign cnt_o     = cnt_q;
  assign busy_o    = (occ != '0) | inflt_q;

endmodule
